// File: rtl/add_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : add_sched_pkg                                                |
// | Purpose : Shared helpers for the shared-adder scheduler. Holds the     |
// |           constant function used to derive the fixed-point formats.    |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package add_sched_pkg;

  // Constant-foldable maximum, used in localparam derivations.
  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : add_sched_if                                                 |
// | Purpose : Requester-side and result-side signals of the shared-adder   |
// |           scheduler.                                                   |
// | Ports   : req/a_in/b_in -> ack (request side, operands packed per id)  |
// |           out_valid/out_ready/out_id/out_sum (result side)             |
// |           master = requesters + result sink, slave = scheduler         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface add_sched_if #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int N_BITS_A   = 3,
  parameter int N_BITS_B   = 4,
  parameter int N_BITS_OUT = 6
) ();
  logic [N_REQ-1:0]          req;
  logic [N_REQ*N_BITS_A-1:0] a_in;
  logic [N_REQ*N_BITS_B-1:0] b_in;
  logic [N_REQ-1:0]          ack;
  logic                      out_valid;
  logic                      out_ready;
  logic [ID_W-1:0]           out_id;
  logic [N_BITS_OUT-1:0]     out_sum;

  modport master (
    output req, a_in, b_in, out_ready,
    input  ack, out_valid, out_id, out_sum
  );

  modport slave (
    input  req, a_in, b_in, out_ready,
    output ack, out_valid, out_id, out_sum
  );
endinterface
`default_nettype wire

// File: rtl/add.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : add                                                          |
// | Purpose : Combinational signed fixed-point adder. Aligns both operands |
// |           to (N_BITS_OUT, BIN_PT_OUT) by sign extension and LSB zero   |
// |           padding, then adds modulo 2^N_BITS_OUT.                      |
// | Ports   : a[N_BITS_A]     in  operand a, (N_BITS_A, BIN_PT_A)          |
// |           b[N_BITS_B]     in  operand b, (N_BITS_B, BIN_PT_B)          |
// |           sum[N_BITS_OUT] out aligned sum                              |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module add #(
  parameter int N_BITS_A   = 3,
  parameter int BIN_PT_A   = 1,
  parameter int N_BITS_B   = 4,
  parameter int BIN_PT_B   = 3,
  parameter int N_BITS_OUT = 6,
  parameter int BIN_PT_OUT = 3
) (
  input  logic [N_BITS_A-1:0]   a,
  input  logic [N_BITS_B-1:0]   b,
  output logic [N_BITS_OUT-1:0] sum
);

  localparam int SHIFT_A = BIN_PT_OUT - BIN_PT_A;
  localparam int SHIFT_B = BIN_PT_OUT - BIN_PT_B;

  logic [N_BITS_OUT-1:0] w_a_al;
  logic [N_BITS_OUT-1:0] w_b_al;

  // Sized cast of a signed operand sign-extends; the shift zero-pads LSBs.
  assign w_a_al = N_BITS_OUT'($signed(a)) << SHIFT_A;
  assign w_b_al = N_BITS_OUT'($signed(b)) << SHIFT_B;
  assign sum    = w_a_al + w_b_al;

endmodule
`default_nettype wire

// File: rtl/add_sched_defs.vh
// +------------------------------------------------------------------------+
// | File    : add_sched_defs.vh                                            |
// | Purpose : Derived fixed-point format constants and a parameter         |
// |           consistency check. Included inside the add_sched module      |
// |           body; relies on its parameters and on add_sched_pkg.         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+

// Integer bits (including sign) of each operand and of the sum.
localparam int INT_A   = N_BITS_A - BIN_PT_A;
localparam int INT_B   = N_BITS_B - BIN_PT_B;
localparam int INT_OUT = N_BITS_OUT - BIN_PT_OUT;

// Output format implied by the operand formats.
localparam int BIN_PT_OUT_CALC = max_int(BIN_PT_A, BIN_PT_B);
localparam int N_BITS_OUT_CALC = max_int(INT_A, INT_B) + 1 + BIN_PT_OUT_CALC;

// Alignment pads: LSB zero-fill and MSB sign-extension per operand.
localparam int PAD_LO_A = BIN_PT_OUT - BIN_PT_A;
localparam int PAD_HI_A = INT_OUT - INT_A;
localparam int PAD_LO_B = BIN_PT_OUT - BIN_PT_B;
localparam int PAD_HI_B = INT_OUT - INT_B;

// Id tag width implied by the requester count.
localparam int ID_W_CALC = (N_REQ > 1) ? $clog2(N_REQ) : 1;

if ((N_BITS_OUT != N_BITS_OUT_CALC) || (BIN_PT_OUT != BIN_PT_OUT_CALC) ||
    (ID_W != ID_W_CALC) || (PAD_LO_A < 0) || (PAD_LO_B < 0) ||
    (PAD_HI_A < 1) || (PAD_HI_B < 1)) begin : g_param_chk
  $error("add_sched: N_BITS_OUT/BIN_PT_OUT/ID_W inconsistent with operand formats");
end

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rr_arbiter                                                   |
// | Purpose : Combinational round-robin pick. Searches req upward from     |
// |           pointer+1 (mod N_REQ) and grants the first set index.        |
// | Ports   : req[N_REQ]      in  request vector                           |
// |           pointer[ID_W]   in  last granted index                       |
// |           enable          in  grant allowed this cycle                 |
// |           grant[N_REQ]    out one-hot grant (zero when none)           |
// |           grant_idx[ID_W] out binary index of grant                    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  pointer,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic            w_found;
  logic [ID_W-1:0] w_cand;

  // k=N_REQ wraps back to pointer itself, so the last grantee is
  // considered only when nobody else is requesting.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = ID_W'((int'(pointer) + k) % N_REQ);
      if (enable && !w_found && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/add_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : add_sched                                                    |
// | Purpose : Round-robin scheduler sharing one fixed-point adder among    |
// |           N_REQ requesters. Two register stages: S1 holds the granted  |
// |           operands and id, S2 holds the tagged sum. Full throughput    |
// |           with valid/ready backpressure on the result.                 |
// | Ports   : clk  in  rising-edge clock                                   |
// |           rst  in  asynchronous active-high reset                      |
// |           bus  slave modport of add_sched_if (req/a_in/b_in/ack,       |
// |                out_valid/out_ready/out_id/out_sum)                     |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module add_sched
  import add_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int N_BITS_A   = 3,
  parameter int BIN_PT_A   = 1,
  parameter int N_BITS_B   = 4,
  parameter int BIN_PT_B   = 3,
  parameter int N_BITS_OUT = 6,
  parameter int BIN_PT_OUT = 3
) (
  input  logic     clk,
  input  logic     rst,
  add_sched_if.slave bus
);

  `include "add_sched_defs.vh"

  logic [ID_W-1:0]       r_ptr;
  logic                  r_s1_valid;
  logic [ID_W-1:0]       r_s1_id;
  logic [N_BITS_A-1:0]   r_s1_a;
  logic [N_BITS_B-1:0]   r_s1_b;
  logic                  r_out_valid;
  logic [ID_W-1:0]       r_out_id;
  logic [N_BITS_OUT-1:0] r_out_sum;

  logic                  w_s2_adv;
  logic                  w_s1_adv;
  logic                  w_arb_en;
  logic [N_REQ-1:0]      w_grant;
  logic [ID_W-1:0]       w_grant_idx;
  logic                  w_grant_any;
  logic [N_BITS_A-1:0]   w_a_sel;
  logic [N_BITS_B-1:0]   w_b_sel;
  logic [N_BITS_OUT-1:0] w_sum;

  assign w_s2_adv = !r_out_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  // Gating with rst keeps ack low for the whole reset window, not just
  // after the registers have cleared.
  assign w_arb_en = w_s1_adv && !rst;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (bus.req),
    .pointer   (r_ptr),
    .enable    (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_grant_any = |w_grant;
  assign w_a_sel     = bus.a_in[int'(w_grant_idx)*N_BITS_A +: N_BITS_A];
  assign w_b_sel     = bus.b_in[int'(w_grant_idx)*N_BITS_B +: N_BITS_B];

  add #(
    .N_BITS_A   (N_BITS_A),
    .BIN_PT_A   (BIN_PT_A),
    .N_BITS_B   (N_BITS_B),
    .BIN_PT_B   (BIN_PT_B),
    .N_BITS_OUT (N_BITS_OUT),
    .BIN_PT_OUT (BIN_PT_OUT)
  ) u_add (
    .a   (r_s1_a),
    .b   (r_s1_b),
    .sum (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= ID_W'(N_REQ - 1);
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_sum   <= '0;
    end else begin
      // A grant implies S1 is free or draining this edge, so the load
      // never overwrites an unmoved entry.
      if (w_grant_any) begin
        r_s1_valid <= 1'b1;
        r_s1_id    <= w_grant_idx;
        r_s1_a     <= w_a_sel;
        r_s1_b     <= w_b_sel;
        r_ptr      <= w_grant_idx;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        r_out_id    <= r_s1_id;
        r_out_sum   <= w_sum;
      end
    end
  end

  assign bus.ack       = w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_id    = r_out_id;
  assign bus.out_sum   = r_out_sum;

endmodule
`default_nettype wire

// File: tb/tb_add_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_add_sched                                                 |
// | Purpose : Self-checking bench for add_sched: fixed vector table,       |
// |           hand-written corner sequences and randomized traffic scored  |
// |           against a queue-based reference model.                       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_add_sched;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int NA    = 3;
  localparam int BA    = 1;
  localparam int NB    = 4;
  localparam int BB    = 3;
  localparam int NO    = 6;
  localparam int BO    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_sched_if #(
    .N_REQ(N_REQ), .ID_W(ID_W), .N_BITS_A(NA), .N_BITS_B(NB), .N_BITS_OUT(NO)
  ) bus ();

  add_sched #(
    .N_REQ(N_REQ), .ID_W(ID_W), .N_BITS_A(NA), .BIN_PT_A(BA),
    .N_BITS_B(NB), .BIN_PT_B(BB), .N_BITS_OUT(NO), .BIN_PT_OUT(BO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {int idx; int a; int b; int sum;} vec_t;
  typedef struct {int id; int sum;} res_t;

  vec_t tbl [8];
  res_t q [$];
  int   total    = 0;
  int   bad      = 0;
  int   m_ptr    = N_REQ - 1;
  int   last_gnt = -1;

  // Real-valued sum scaled by 2^BO, wrapped to NO bits.
  function automatic int ref_sum(input int ar, input int br);
    int av, bv, s;
    av = (ar >= (1 << (NA-1))) ? ar - (1 << NA) : ar;
    bv = (br >= (1 << (NB-1))) ? br - (1 << NB) : br;
    s  = av * (1 << (BO-BA)) + bv * (1 << (BO-BB));
    return ((s % (1 << NO)) + (1 << NO)) % (1 << NO);
  endfunction

  function automatic int rr_pick(input int rv, input int ptr);
    int i;
    for (int k = 1; k <= N_REQ; k++) begin
      i = (ptr + k) % N_REQ;
      if (rv[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    bus.a_in[i*NA +: NA] = NA'(a);
    bus.b_in[i*NB +: NB] = NB'(b);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req       = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    q.delete();
    m_ptr    = N_REQ - 1;
    last_gnt = -1;
    @(posedge clk);
    #1;
  endtask

  // One clock of model-checked operation. The pipeline holds at most two
  // results; with two in flight and the sink stalled, no grant may occur.
  task automatic cycle_check(input string tag);
    int rv, idx, ea, oid, osum, nsum;
    bit acc;
    res_t r;
    @(negedge clk);
    rv = int'(bus.req);
    if (q.size() >= 2 && !bus.out_ready) idx = -1;
    else idx = rr_pick(rv, m_ptr);
    ea = (idx < 0) ? 0 : (1 << idx);
    check({tag, " ack"}, int'(bus.ack), ea);
    if (q.size() == 0) check({tag, " valid_empty"}, int'(bus.out_valid), 0);
    if (q.size() >= 2) check({tag, " valid_full"}, int'(bus.out_valid), 1);
    acc  = bus.out_valid && bus.out_ready;
    oid  = int'(bus.out_id);
    osum = int'(bus.out_sum);
    nsum = 0;
    if (idx >= 0) nsum = ref_sum(int'(bus.a_in[idx*NA +: NA]), int'(bus.b_in[idx*NB +: NB]));
    @(posedge clk);
    #1;
    if (acc) begin
      if (q.size() == 0) begin
        check({tag, " extra_result"}, int'(acc), 0);
      end else begin
        r = q.pop_front();
        check({tag, " out_id"}, oid, r.id);
        check({tag, " out_sum"}, osum, r.sum);
      end
    end
    if (idx >= 0) begin
      r.id  = idx;
      r.sum = nsum;
      q.push_back(r);
      m_ptr = idx;
    end
    last_gnt = idx;
  endtask

  initial begin
    tbl[0] = '{0, 0, 1, 1};
    tbl[1] = '{1, 7, 1, 61};
    tbl[2] = '{2, 6, 12, 52};
    tbl[3] = '{3, 3, 14, 10};
    tbl[4] = '{2, 4, 8, 40};
    tbl[5] = '{1, 3, 7, 19};
    tbl[6] = '{3, 0, 0, 0};
    tbl[7] = '{0, 4, 15, 47};

    bus.a_in = '0;
    bus.b_in = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset out_id", int'(bus.out_id), 0);
    check("reset out_sum", int'(bus.out_sum), 0);
    @(posedge clk);
    #1;

    // All four requesting at once: in-order acks, back-to-back results
    for (int i = 0; i < 4; i++) set_ops(i, tbl[i].a, tbl[i].b);
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("all4 ack", int'(bus.ack), (c < 4) ? (1 << c) : 0);
      if (c < 2) begin
        check("all4 valid_early", int'(bus.out_valid), 0);
      end else begin
        check("all4 valid", int'(bus.out_valid), 1);
        check("all4 id", int'(bus.out_id), c - 2);
        check("all4 sum", int'(bus.out_sum), tbl[c-2].sum);
      end
      @(posedge clk);
      #1;
      if (c < 4) bus.req[c] = 1'b0;
    end

    // Table of single transactions: ack, 2-cycle latency, id and sum
    for (int e = 0; e < 8; e++) begin
      set_ops(tbl[e].idx, tbl[e].a, tbl[e].b);
      bus.req       = N_REQ'(1 << tbl[e].idx);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("tbl ack", int'(bus.ack), 1 << tbl[e].idx);
      @(posedge clk);
      #1 bus.req = '0;
      @(negedge clk);
      check("tbl valid_lat1", int'(bus.out_valid), 0);
      check("tbl ack_idle", int'(bus.ack), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("tbl valid_lat2", int'(bus.out_valid), 1);
      check("tbl id", int'(bus.out_id), tbl[e].idx);
      check("tbl sum", int'(bus.out_sum), tbl[e].sum);
      @(posedge clk);
      #1;
    end

    // Fairness between requesters 0 and 2
    do_reset();
    bus.req = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("fair ack", int'(bus.ack), (c % 2 == 0) ? 1 : 4);
      @(posedge clk);
      #1;
    end
    bus.req = '0;

    // Backpressure: sink stalls for cycles 3..6 under full load
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_ops(i, $urandom_range(0, 7), $urandom_range(0, 15));
    bus.req = 4'b1111;
    for (int c = 0; c < 14; c++) begin
      bus.out_ready = !(c >= 3 && c <= 6);
      cycle_check("bp");
      if (last_gnt >= 0) set_ops(last_gnt, $urandom_range(0, 7), $urandom_range(0, 15));
    end
    bus.req       = '0;
    bus.out_ready = 1'b1;
    repeat (4) cycle_check("bp_drain");
    check("bp leftover", q.size(), 0);

    // Asynchronous reset with both stages full
    do_reset();
    bus.req       = 4'b1111;
    bus.out_ready = 1'b0;
    repeat (3) cycle_check("rstmid");
    #2 rst = 1'b1;
    #1;
    check("rstmid out_valid", int'(bus.out_valid), 0);
    check("rstmid ack", int'(bus.ack), 0);
    q.delete();
    m_ptr = N_REQ - 1;
    @(posedge clk);
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rstmid first_ack", int'(bus.ack), 1);
    repeat (3) cycle_check("rstmid_run");
    bus.req = '0;
    repeat (4) cycle_check("rstmid_drain");
    check("rstmid leftover", q.size(), 0);

    // Idle, then a single late requester acked combinationally
    do_reset();
    repeat (5) begin
      @(negedge clk);
      check("idle ack", int'(bus.ack), 0);
      check("idle valid", int'(bus.out_valid), 0);
      @(posedge clk);
      #1;
    end
    bus.req = 4'b1000;
    #1;
    check("idle late_ack", int'(bus.ack), 8);

    // Randomized traffic against the queue model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N_REQ; i++) begin
        if (last_gnt == i) begin
          bus.req[i] = 1'($urandom_range(0, 1));
          set_ops(i, $urandom_range(0, 7), $urandom_range(0, 15));
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.req[i] = 1'b1;
            set_ops(i, $urandom_range(0, 7), $urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      cycle_check("rand");
    end
    bus.req       = '0;
    bus.out_ready = 1'b1;
    repeat (4) cycle_check("rand_drain");
    check("rand leftover", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_sched.md
Name: add_sched

Overview:
- Round-robin scheduler that shares one fixed-point adder between N_REQ requesters.
- Each requester presents a signed operand pair in fixed (a, b) formats. The block arbitrates, registers the winning operands, and computes the aligned sum through one instance of the team's combinational `add` block. It returns a registered result tagged with the requester id, under valid/ready backpressure.
- Sits between per-channel accumulation/correction logic and the single shared adder resource.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of the requester id tag; equals clog2(N_REQ).
- N_BITS_A, 3, total bits of operand a (two's complement).
- BIN_PT_A, 1, fractional bits of a.
- N_BITS_B, 4, total bits of operand b.
- BIN_PT_B, 3, fractional bits of b.
- N_BITS_OUT, 6, sum width. Equals max(integer bits of a, b) + 1 + BIN_PT_OUT.
- BIN_PT_OUT, 3, sum fractional bits. Equals max(BIN_PT_A, BIN_PT_B).

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- req, in, N_REQ, per-requester request. Held with operands until acked.
- a_in, in, N_REQ*N_BITS_A, packed operand a. Requester i occupies bits [i*N_BITS_A +: N_BITS_A].
- b_in, in, N_REQ*N_BITS_B, packed operand b, same packing.
- ack, out, N_REQ, one-hot grant. Operands are captured at the rising edge where ack[i]=1.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result when out_valid && out_ready at a rising edge.
- out_id, out, ID_W, id of the requester that owns out_sum.
- out_sum, out, N_BITS_OUT, signed fixed-point sum in format (N_BITS_OUT, BIN_PT_OUT).

Behaviour:
- Reset, asynchronous, immediate:
  - out_valid=0, out_id=0, out_sum=0.
  - Stage-1 valid=0.
  - Round-robin pointer=N_REQ-1, so requester 0 has first priority.
  - ack is forced to 0 while rst=1.
- Pipeline has two registered stages:
  - S1 holds the operand register, id and valid bit.
  - S2 holds out_sum, out_id and out_valid.
  - The adder is purely combinational between S1 and S2.
- Latency: capture at edge t, then out_valid=1 after edge t+1, i.e. 2 cycles request-to-result.
- Stall signals:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
- ack is a combinational function of req, pointer and s1_adv:
  - When s1_adv=1 and req is nonzero, ack goes one-hot to the first set req index searching from pointer+1 upward, modulo N_REQ.
  - Otherwise ack=0.
- At an edge with ack[i]=1:
  - S1 loads a_in/b_in slice i with id=i and valid=1.
  - pointer becomes i.
- Pointer is unchanged on edges without a grant.
- S1 to S2 transfer occurs when s2_adv=1. On that edge S2 loads the adder result and S1's id and valid. If no new grant occurs on the same edge, S1 valid clears.
- Simultaneous grant and transfer on one edge: both happen, giving full throughput of 1 result per cycle.
- Backpressure: while out_valid && !out_ready, S2 holds all values stable. S1 holds once it is full. No ack is issued.
- Results are never dropped or duplicated. Order of out_id equals grant order.
- req deasserted before ack has no effect; the block keeps no pending state per requester.
- Arithmetic:
  - Each operand is sign-extended on the MSB side and zero-padded on the LSB side to (N_BITS_OUT, BIN_PT_OUT).
  - The padded operands are added modulo 2^N_BITS_OUT.
  - With the formula-derived N_BITS_OUT, overflow cannot occur.
- Reset mid-operation discards all in-flight results. After release, arbitration restarts from requester 0.

Decomposition:
- Shared include file `add_sched_defs.vh` holds:
  - the derived localparams: integer bits of a, b and out; pad widths; ID_W formula;
  - a parameter-consistency check (simulation-time $error if N_BITS_OUT or BIN_PT_OUT mismatch the formulas).
- One sub-module: `rr_arbiter` (N_REQ, req, pointer, enable, one-hot grant, grant index).
- The existing `add` block is instantiated once for the datapath.

Test Plan:
1. Single requester: req=0001, a0=000, b0=0001, out_ready=1.
   - ack=0001 at edge 0.
   - Two cycles later: out_valid=1, out_id=0, out_sum=000001 (1/8).
2. All four requesting at once, out_ready=1. Operands: (a0,b0)=(000,0001), (a1,b1)=(111,0001), (a2,b2)=(110,1100), (a3,b3)=(011,1110).
   - Acks appear in order 0,1,2,3 on consecutive edges.
   - Results arrive back-to-back: id0 000001, id1 111101 (-3/8), id2 110100 (-3/2), id3 001010 (5/4).
3. Fairness: req[0] and req[2] held high continuously for 8 cycles, out_ready=1.
   - Grant sequence is 0,2,0,2,...
   - No requester waits more than N_REQ-1 grants.
4. Backpressure: continuous requests from all, out_ready=0 for cycles 3..6.
   - S2 and S1 stay full with outputs stable, and ack=0.
   - After out_ready=1, the results sequence matches grant order, with no gaps lost and no repeats.
5. Reset mid-flight: assert rst asynchronously (between edges) while both stages are full.
   - out_valid and ack fall immediately.
   - After release with req=1111, the first ack is 0001.
6. Idle and partial: req=0000 gives ack=0 and out_valid=0 indefinitely. Then req=1000 gives ack=1000 within the same cycle.
